// File: rtl/mealy_seq_pkg.sv
// Shared state encoding and transition/decode functions for the 4-state Mealy
// sequence encoder and its decoder.
package mealy_seq_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_e;

  // Transition on the original (unencoded) bit x.
  function automatic state_e next_state(input state_e state, input logic x);
    state_e nxt;
    nxt = S0;
    case (state)
      S0: nxt = x ? S0 : S1;
      S1: nxt = x ? S3 : S2;
      S2: nxt = x ? S1 : S0;
      S3: nxt = x ? S2 : S3;
      default: nxt = S0;
    endcase
    return nxt;
  endfunction

  // S1/S2 invert the bit on the line; S0/S3 pass it through.
  function automatic logic invert_state(input state_e state);
    return (state == S1) || (state == S2);
  endfunction

  function automatic logic decode_bit(input state_e state, input logic y);
    return invert_state(state) ? ~y : y;
  endfunction

  function automatic logic encode_bit(input state_e state, input logic x);
    return invert_state(state) ? ~x : x;
  endfunction

endpackage

// File: rtl/mealy_seq_tracker.sv
// Tracks the remote encoder's state from the received stream and decodes
// the current bit combinationally.
module mealy_seq_tracker
  import mealy_seq_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clr,
  input  logic   adv,
  input  logic   y_in,
  output state_e state_q,
  output logic   x_c
);

  state_e state_d;

  assign x_c = decode_bit(state_q, y_in);

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S0;
    end else if (adv) begin
      state_d = next_state(state_q, x_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/mealy_seq_decoder.sv
// Mealy sequence decoder: recovers x from the encoded stream and packs it
// LSB-first into WORD_W-bit words. Optional MEALY_DEC_STATE_MON_EN adds state/sync monitors.
module mealy_seq_decoder
  import mealy_seq_pkg::*;
#(
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync,
  input  logic              y_in,
  input  logic              y_valid,
  output logic              y_ready,
  output logic              x_out,
  output logic              x_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
`ifdef MEALY_DEC_STATE_MON_EN
  output logic [1:0]        dbg_state,
  output logic [7:0]        sync_cnt,
`endif
  input  logic              word_ready
);

  localparam int unsigned CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

  state_e            state_q;
  logic              x_c;
  logic              last_bit;
  logic              accept;

  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] word_out_q, word_out_d;
  logic              word_valid_q, word_valid_d;
  logic              x_out_q, x_out_d;
  logic              x_valid_q, x_valid_d;

  // Stall only the word-completing bit while an unconsumed word is held.
  assign last_bit = (bit_cnt_q == LAST);
  assign y_ready  = !sync && !(word_valid_q && !word_ready && last_bit);
  assign accept   = y_valid && y_ready;

  mealy_seq_tracker u_tracker (
    .clk     (clk),
    .rst     (rst),
    .clr     (sync),
    .adv     (accept),
    .y_in    (y_in),
    .state_q (state_q),
    .x_c     (x_c)
  );

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    word_out_d   = word_out_q;
    word_valid_d = word_valid_q;
    x_out_d      = x_out_q;
    x_valid_d    = accept;
    if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end
    if (sync) begin
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (accept) begin
      x_out_d            = x_c;
      shift_d[bit_cnt_q] = x_c;
      if (last_bit) begin
        word_out_d   = shift_d;
        word_valid_d = 1'b1;
        bit_cnt_d    = '0;
        shift_d      = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      x_out_q      <= 1'b0;
      x_valid_q    <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      x_out_q      <= x_out_d;
      x_valid_q    <= x_valid_d;
    end
  end

  assign x_out      = x_out_q;
  assign x_valid    = x_valid_q;
  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;

`ifdef MEALY_DEC_STATE_MON_EN
  logic [7:0] sync_cnt_q, sync_cnt_d;

  // Saturating count of cycles with sync asserted.
  always_comb begin
    sync_cnt_d = sync_cnt_q;
    if (sync && (sync_cnt_q != 8'hFF)) begin
      sync_cnt_d = sync_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_cnt_q <= '0;
    end else begin
      sync_cnt_q <= sync_cnt_d;
    end
  end

  assign dbg_state = state_q;
  assign sync_cnt  = sync_cnt_q;
`endif

endmodule
